delay_sum_array: RTL



---
 rtl/delay_sum_pkg.sv | 24 ++
 rtl/delay_line_ch.sv | 35 +++
 rtl/delay_sum_array.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/delay_sum_pkg.sv
// Shared types and helpers for the delay-and-sum beamformer.
// State encoding, ceil-log2 and default pipeline depth constants.
package delay_sum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int DEF_NUM_CH = 8;
  localparam int TREE_LVL   = clog2(DEF_NUM_CH);
  localparam int LAT        = 2 + TREE_LVL;

endpackage

// File: rtl/delay_line_ch.sv
// Per-channel circular delay buffer with a registered read port.
// A zero delay forwards the incoming sample, as it is not yet in RAM.
module delay_line_ch
  import delay_sum_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 2048,
  parameter int DELAY_W  = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic [DELAY_W-1:0]  wr_ptr_i,
  input  logic [DELAY_W-1:0]  delay_i,
  input  logic [SAMPLE_W-1:0] din_i,
  output logic [SAMPLE_W-1:0] dout_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rd_q;
  logic [DELAY_W-1:0]  rd_addr;

  assign rd_addr = wr_ptr_i - delay_i;

  always_ff @(posedge clk) begin
    if (en_i) mem_q[wr_ptr_i] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (en_i)
      rd_q <= (delay_i == '0) ? din_i : mem_q[rd_addr];
  end

  assign dout_o = rd_q;

endmodule

// File: rtl/delay_sum_array.sv
// Streaming delay-and-sum beamformer: per-channel delay lines,
// masked registered adder tree, optional averaging, valid/ready out.
module delay_sum_array
  import delay_sum_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 2048,
  parameter int DELAY_W  = clog2(DEPTH),
  parameter int OUT_W    = SAMPLE_W + clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cfg_we,
  input  logic [clog2(NUM_CH)-1:0]   cfg_ch,
  input  logic [DELAY_W-1:0]         cfg_delay,
  output logic                       cfg_err,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic                       avg_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_last,
  output logic                       busy
);

  localparam int LVL = clog2(NUM_CH);
  localparam int EXT = OUT_W - SAMPLE_W;

  state_e state_q, state_d;

  logic [DELAY_W-1:0]      delay_q [NUM_CH];
  logic [NUM_CH-1:0]       mask_q;
  logic                    avg_q;
  logic [DELAY_W-1:0]      wr_ptr_q;
  logic [DELAY_W:0]        fill_q, fill_d;
  logic [DELAY_W-1:0]      max_dly;
  logic [LVL:0]            vp_q, lp_q;
  logic signed [OUT_W-1:0] node_q [1:NUM_CH-1];
  logic signed [OUT_W-1:0] leaf [NUM_CH];
  logic [SAMPLE_W-1:0]     rd [NUM_CH];
  logic signed [OUT_W-1:0] out_data_q;
  logic                    out_valid_q, out_last_q, cfg_err_q;
  logic                    stall, accept, produce, empty;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = (state_q == FILL || state_q == RUN) && !stall;
  assign accept   = in_valid && in_ready;
  assign fill_d   = fill_q + {{DELAY_W{1'b0}}, accept};
  assign empty    = !(|vp_q) && !out_valid_q;

  // Beats before max_dly only prime the delay lines.
  assign produce = accept &&
                   (state_q == RUN || fill_q >= {1'b0, max_dly});

  always_comb begin
    max_dly = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (mask_q[k] && delay_q[k] > max_dly) max_dly = delay_q[k];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL: begin
        if (accept && in_last)                 state_d = DRAIN;
        else if (fill_d >= {1'b0, max_dly})    state_d = RUN;
      end
      RUN:   if (accept && in_last) state_d = DRAIN;
      DRAIN: if (empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      avg_q     <= 1'b0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) delay_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_we && state_q != IDLE;
      if (cfg_we && state_q == IDLE) delay_q[cfg_ch] <= cfg_delay;
      if (state_q == IDLE && start) begin
        mask_q <= ch_mask;
        avg_q  <= avg_mode;
        fill_q <= '0;
      end else if (state_q == FILL) begin
        fill_q <= fill_d;
      end
      if (accept) wr_ptr_q <= wr_ptr_q + DELAY_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    delay_line_ch #(
      .SAMPLE_W(SAMPLE_W),
      .DEPTH   (DEPTH),
      .DELAY_W (DELAY_W)
    ) u_line (
      .clk     (clk),
      .en_i    (accept),
      .wr_ptr_i(wr_ptr_q),
      .delay_i (delay_q[k]),
      .din_i   (in_data[k*SAMPLE_W +: SAMPLE_W]),
      .dout_o  (rd[k])
    );
    assign leaf[k] = mask_q[k] ?
      {{EXT{rd[k][SAMPLE_W-1]}}, rd[k]} : '0;
  end

  // Heap-ordered tree: node i sums 2i and 2i+1, leaves past NUM_CH-1.
  for (genvar i = 1; i < NUM_CH; i++) begin : g_node
    if (2 * i >= NUM_CH) begin : g_bot
      always_ff @(posedge clk) begin
        if (!stall)
          node_q[i] <= leaf[2*i-NUM_CH] + leaf[2*i+1-NUM_CH];
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (!stall) node_q[i] <= node_q[2*i] + node_q[2*i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vp_q        <= '0;
      lp_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      vp_q        <= {vp_q[LVL-1:0], produce};
      lp_q        <= {lp_q[LVL-1:0], produce && in_last};
      out_valid_q <= vp_q[LVL];
      out_last_q  <= lp_q[LVL];
      if (vp_q[LVL])
        out_data_q <= avg_q ? node_q[1] >>> LVL : node_q[1];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = state_q != IDLE;

endmodule
